// File: rtl/xnort_pulse_sequencer.sv
// rtl/xnort_pulse_sequencer.sv - toggle-encoded pulse sequencer and q-window checker for one XNOR-T cell
module xnort_pulse_sequencer #(
    parameter int DATA_GAP    = 12,
    parameter int DATA_TO_CLK = 19,
    parameter int CLK_TO_DATA = 13,
    parameter int CLK_TO_CLK  = 30,
    parameter int CLK_TO_Q    = 19,
    parameter int Q_WIN       = 4,
    parameter int CW          = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic op_valid,
    output logic op_ready,
    input  logic op_a,
    input  logic op_b,
    output logic a_tgl,
    output logic b_tgl,
    output logic clk_tgl,
    input  logic q_tgl,
    output logic res_valid,
    output logic res_q,
    output logic res_err,
    output logic stray_err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        ISSUE_CLK,
        WAIT_Q,
        REPORT
    } state_t;

    // A counter holds "cycles since the last pulse", so a pulse may fire at the
    // next edge once the counter reaches spacing-1.
    localparam logic [CW-1:0] A_THR   = CW'(CLK_TO_DATA - 1);
    localparam logic [CW-1:0] GAP_THR = CW'(DATA_GAP - 1);
    localparam logic [CW-1:0] D2C_THR = CW'(DATA_TO_CLK - 1);
    localparam logic [CW-1:0] C2C_THR = CW'(CLK_TO_CLK - 1);
    localparam logic [CW-1:0] WIN_LO  = CW'(CLK_TO_Q - Q_WIN);
    localparam logic [CW-1:0] WIN_HI  = CW'(CLK_TO_Q + Q_WIN);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q;
    logic          op_ready_q;
    logic          res_valid_q;
    logic          res_q_q;
    logic          res_err_q;
    logic          stray_err_q;
    logic          opb_q;
    logic          exp_q;
    logic          a_done_q;
    logic          data_done_q;
    logic          a_tgl_q;
    logic          b_tgl_q;
    logic          clk_tgl_q;
    logic          q_prev_q;
    logic          pend_q;
    logic          par_q;
    logic          seen_q;
    logic          multi_q;
    logic [CW-1:0] cnt_a_q;
    logic [CW-1:0] cnt_data_q;
    logic [CW-1:0] cnt_clk_q;
    logic [CW-1:0] win_q;

    logic hs;
    logic a_ok;
    logic b_ok;
    logic clk_ok;
    logic fire_a;
    logic fire_b;
    logic fire_clk;
    logic q_edge;
    logic win_active;
    logic stray;
    logic par_fin;
    logic multi_fin;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    assign hs         = op_valid & op_ready_q;
    assign q_edge     = q_tgl ^ q_prev_q;
    assign win_active = (state_q == WAIT_Q) && (win_q >= WIN_LO) && (win_q <= WIN_HI);
    assign stray      = q_edge & ~win_active;
    assign par_fin    = par_q ^ (q_edge & win_active);
    assign multi_fin  = multi_q | (seen_q & q_edge & win_active);

    // Spacing checks; a saturated counter always satisfies its spacing.
    assign a_ok   = (cnt_clk_q >= A_THR) || (cnt_clk_q == CNT_MAX);
    assign b_ok   = a_ok && (!a_done_q || (cnt_a_q >= GAP_THR) || (cnt_a_q == CNT_MAX));
    assign clk_ok = ((cnt_clk_q >= C2C_THR) || (cnt_clk_q == CNT_MAX)) &&
                    (!data_done_q || (cnt_data_q >= D2C_THR) || (cnt_data_q == CNT_MAX));

    // Decide which line (if any) inverts at the coming edge; the handshake
    // cycle itself may fire so the first pulse lands at T+1.
    always_comb begin
        fire_a   = 1'b0;
        fire_b   = 1'b0;
        fire_clk = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (op_a) begin
                        fire_a = a_ok;
                    end else if (op_b) begin
                        fire_b = b_ok;
                    end else begin
                        fire_clk = clk_ok;
                    end
                end
            end
            ISSUE_A:   fire_a   = a_ok;
            ISSUE_B:   fire_b   = b_ok;
            ISSUE_CLK: fire_clk = clk_ok;
            default: begin
                fire_a   = 1'b0;
                fire_b   = 1'b0;
                fire_clk = 1'b0;
            end
        endcase
    end

    // Operation sequencing, window accounting and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_q_q     <= 1'b0;
            res_err_q   <= 1'b0;
            opb_q       <= 1'b0;
            exp_q       <= 1'b0;
            a_done_q    <= 1'b0;
            data_done_q <= 1'b0;
            win_q       <= '0;
            par_q       <= 1'b0;
            seen_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (fire_a) begin
                a_done_q <= 1'b1;
            end
            if (fire_a || fire_b) begin
                data_done_q <= 1'b1;
            end
            if (fire_clk) begin
                win_q   <= '0;
                par_q   <= 1'b0;
                seen_q  <= 1'b0;
                multi_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        op_ready_q <= 1'b0;
                        opb_q      <= op_b;
                        exp_q      <= ~(op_a ^ op_b);
                        if (op_a) begin
                            state_q <= !fire_a ? ISSUE_A : (op_b ? ISSUE_B : ISSUE_CLK);
                        end else if (op_b) begin
                            state_q <= fire_b ? ISSUE_CLK : ISSUE_B;
                        end else begin
                            state_q <= fire_clk ? WAIT_Q : ISSUE_CLK;
                        end
                    end else begin
                        op_ready_q <= 1'b1;
                    end
                end
                ISSUE_A: begin
                    if (fire_a) begin
                        state_q <= opb_q ? ISSUE_B : ISSUE_CLK;
                    end
                end
                ISSUE_B: begin
                    if (fire_b) begin
                        state_q <= ISSUE_CLK;
                    end
                end
                ISSUE_CLK: begin
                    if (fire_clk) begin
                        state_q <= WAIT_Q;
                    end
                end
                WAIT_Q: begin
                    win_q <= win_q + CW'(1);
                    if (q_edge && win_active) begin
                        par_q   <= ~par_q;
                        multi_q <= multi_q | seen_q;
                        seen_q  <= 1'b1;
                    end
                    if (win_q == WIN_HI) begin
                        res_valid_q <= 1'b1;
                        res_q_q     <= par_fin;
                        res_err_q   <= (par_fin != exp_q) | multi_fin | pend_q;
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    state_q     <= IDLE;
                    op_ready_q  <= 1'b1;
                    a_done_q    <= 1'b0;
                    data_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    op_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Free-running saturating spacing counters, cleared by their own pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q    <= CNT_MAX;
            cnt_data_q <= CNT_MAX;
            cnt_clk_q  <= CNT_MAX;
        end else begin
            cnt_a_q    <= fire_a ? '0 : sat_inc(cnt_a_q);
            cnt_data_q <= (fire_a || fire_b) ? '0 : sat_inc(cnt_data_q);
            cnt_clk_q  <= fire_clk ? '0 : sat_inc(cnt_clk_q);
        end
    end

    // Toggle-encoded lines to the cell: each pulse inverts its line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_tgl_q   <= 1'b0;
            b_tgl_q   <= 1'b0;
            clk_tgl_q <= 1'b0;
        end else begin
            a_tgl_q   <= a_tgl_q ^ fire_a;
            b_tgl_q   <= b_tgl_q ^ fire_b;
            clk_tgl_q <= clk_tgl_q ^ fire_clk;
        end
    end

    // q edge history and stray tracking; REPORT hands any new stray to the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev_q    <= 1'b0;
            pend_q      <= 1'b0;
            stray_err_q <= 1'b0;
        end else begin
            q_prev_q    <= q_tgl;
            stray_err_q <= stray_err_q | stray;
            if (state_q == REPORT) begin
                pend_q <= stray;
            end else begin
                pend_q <= pend_q | stray;
            end
        end
    end

    assign op_ready  = op_ready_q;
    assign a_tgl     = a_tgl_q;
    assign b_tgl     = b_tgl_q;
    assign clk_tgl   = clk_tgl_q;
    assign res_valid = res_valid_q;
    assign res_q     = res_q_q;
    assign res_err   = res_err_q;
    assign stray_err = stray_err_q;

endmodule

// File: tb/tb_xnort_pulse_sequencer.sv
// tb/tb_xnort_pulse_sequencer.sv - scoreboard bench for xnort_pulse_sequencer
module tb_xnort_pulse_sequencer;

    logic clk;
    logic rst_n;
    logic op_valid;
    logic op_ready;
    logic op_a;
    logic op_b;
    logic a_tgl;
    logic b_tgl;
    logic clk_tgl;
    logic q_tgl;
    logic res_valid;
    logic res_q;
    logic res_err;
    logic stray_err;

    typedef struct {
        int cyc;
        bit q;
        bit e;
    } res_t;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   exp_a[$];
    int   exp_b[$];
    int   exp_c[$];
    res_t exp_r[$];
    logic pa;
    logic pb;
    logic pc;

    xnort_pulse_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .a_tgl     (a_tgl),
        .b_tgl     (b_tgl),
        .clk_tgl   (clk_tgl),
        .q_tgl     (q_tgl),
        .res_valid (res_valid),
        .res_q     (res_q),
        .res_err   (res_err),
        .stray_err (stray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: line edges and result strobes are checked against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            pa = a_tgl;
            pb = b_tgl;
            pc = clk_tgl;
        end else begin
            if (a_tgl !== pa) begin
                if (exp_a.size() == 0) chk("a_edge_unexpected", cyc, -1);
                else chk("a_edge_cycle", cyc, exp_a.pop_front());
                pa = a_tgl;
            end
            if (b_tgl !== pb) begin
                if (exp_b.size() == 0) chk("b_edge_unexpected", cyc, -1);
                else chk("b_edge_cycle", cyc, exp_b.pop_front());
                pb = b_tgl;
            end
            if (clk_tgl !== pc) begin
                if (exp_c.size() == 0) chk("clk_edge_unexpected", cyc, -1);
                else chk("clk_edge_cycle", cyc, exp_c.pop_front());
                pc = clk_tgl;
            end
            if (res_valid) begin
                if (exp_r.size() == 0) begin
                    chk("res_unexpected", cyc, -1);
                end else begin
                    res_t r;
                    r = exp_r.pop_front();
                    chk("res_cycle", cyc, r.cyc);
                    chk("res_q", int'(res_q), int'(r.q));
                    chk("res_err", int'(res_err), int'(r.e));
                end
            end
        end
    end

    // Offsets are relative to the handshake cycle; 0 means no event expected.
    task automatic issue(input bit a, input bit b, input int gap,
                         input int ea, input int eb, input int ec, input int er,
                         input bit rq, input bit re, output int t);
        int n;
        res_t r;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("ready_timeout", 0, 1);
        repeat (gap) @(negedge clk);
        t = cyc;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        if (ea > 0) exp_a.push_back(t + ea);
        if (eb > 0) exp_b.push_back(t + eb);
        if (ec > 0) exp_c.push_back(t + ec);
        if (er > 0) begin
            r.cyc = t + er;
            r.q = rq;
            r.e = re;
            exp_r.push_back(r);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_a = 1'b0;
        op_b = 1'b0;
    endtask

    task automatic q_at(input int tc);
        while (cyc < tc) begin
            @(posedge clk);
            #1;
        end
        q_tgl = ~q_tgl;
    endtask

    task automatic wait_cyc(input int tc);
        while (cyc < tc) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        int t3;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        op_valid = 1'b0;
        op_a = 1'b0;
        op_b = 1'b0;
        q_tgl = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_op_ready", int'(op_ready), 0);
        chk("reset_lines", int'({a_tgl, b_tgl, clk_tgl}), 0);
        chk("reset_res", int'({res_valid, res_q, res_err, stray_err}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(op_ready), 1);

        // a=1 b=1 with a correct q edge
        issue(1'b1, 1'b1, 0, 1, 13, 32, 56, 1'b1, 1'b0, t);
        q_at(t + 51);
        // a=0 b=0, clk only
        issue(1'b0, 1'b0, 40, 0, 0, 1, 25, 1'b1, 1'b0, t);
        q_at(t + 20);
        // a=1 b=0, no q edge (expected 0)
        issue(1'b1, 1'b0, 40, 1, 0, 20, 44, 1'b0, 1'b0, t);
        // a=1 b=0, q edge gives wrong result
        issue(1'b1, 1'b0, 40, 1, 0, 20, 44, 1'b1, 1'b1, t);
        q_at(t + 39);
        // back-to-back: second clk held off by clk-to-clk spacing
        issue(1'b0, 1'b0, 40, 0, 0, 1, 25, 1'b1, 1'b0, t);
        q_at(t + 20);
        issue(1'b0, 1'b0, 0, 0, 0, 5, 29, 1'b1, 1'b0, t2);
        chk("b2b_accept", t2 - t, 26);
        q_at(t2 + 24);
        // stray edge before window plus a correct edge
        issue(1'b0, 1'b0, 40, 0, 0, 1, 25, 1'b1, 1'b1, t);
        wait_cyc(t + 10);
        chk("stray_before", int'(stray_err), 0);
        q_at(t + 11);
        wait_cyc(t + 12);
        chk("stray_after", int'(stray_err), 1);
        q_at(t + 20);
        // two edges in the window
        issue(1'b0, 1'b0, 40, 0, 0, 1, 25, 1'b0, 1'b1, t);
        q_at(t + 18);
        q_at(t + 22);
        // reset while ISSUE_CLK waits on clk-to-clk spacing
        issue(1'b0, 1'b0, 40, 0, 0, 1, 25, 1'b1, 1'b0, t);
        q_at(t + 20);
        issue(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, t2);
        chk("rst_b2b_accept", t2 - t, 26);
        wait_cyc(t2 + 1);
        #2;
        rst_n = 1'b0;
        q_tgl = 1'b0;
        #1;
        chk("arst_a_tgl", int'(a_tgl), 0);
        chk("arst_b_tgl", int'(b_tgl), 0);
        chk("arst_clk_tgl", int'(clk_tgl), 0);
        chk("arst_op_ready", int'(op_ready), 0);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_q", int'(res_q), 0);
        chk("arst_res_err", int'(res_err), 0);
        chk("arst_stray_err", int'(stray_err), 0);
        wait_cyc(t2 + 2);
        #2;
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 0, 0, 0, 1, 25, 1'b1, 1'b0, t3);
        chk("post_reset_accept", t3 - t2, 3);
        q_at(t3 + 20);

        repeat (40) @(negedge clk);
        chk("left_a_edges", exp_a.size(), 0);
        chk("left_b_edges", exp_b.size(), 0);
        chk("left_clk_edges", exp_c.size(), 0);
        chk("left_results", exp_r.size(), 0);
        chk("final_stray_err", int'(stray_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xnort_pulse_sequencer.md
Name: xnort_pulse_sequencer

Overview:
- Synchronous controller that drives one toggle-clocked XNOR-T cell (inputs a, b, clk; output q) from a valid/ready operand interface.
- Emits toggle-encoded a/b/clk lines that respect the cell's critical-timing spacings, then watches q for an edge in a bounded window.
- Reports the observed XNOR result and any timing or functional error.
- Sits between a test or host engine and the cell in characterisation and system harnesses; one clock cycle is one timing tick.

Parameters:
- DATA_GAP, 12, minimum cycles from an a pulse to a b pulse within one operation.
- DATA_TO_CLK, 19, minimum cycles from the last data pulse to the clk pulse.
- CLK_TO_DATA, 13, minimum cycles from a clk pulse to the next data pulse.
- CLK_TO_CLK, 30, minimum cycles between clk pulses.
- CLK_TO_Q, 19, nominal cycles from the clk pulse to the q edge.
- Q_WIN, 4, half-width in cycles of the q observation window.
- CW, 6, width of the spacing counters; must hold max(all spacings) + 1.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- op_valid, in, 1, operand request.
- op_ready, out, 1, sequencer can accept an operand.
- op_a, in, 1, issue an a pulse for this operation.
- op_b, in, 1, issue a b pulse for this operation.
- a_tgl, out, 1, toggle-encoded a line to the cell.
- b_tgl, out, 1, toggle-encoded b line to the cell.
- clk_tgl, out, 1, toggle-encoded clk line to the cell.
- q_tgl, in, 1, cell q line, already synchronous to clk.
- res_valid, out, 1, one-cycle result strobe.
- res_q, out, 1, observed result: 1 if q toggled an odd number of times in the window.
- res_err, out, 1, result mismatch, multiple q edges, or stray edge.
- stray_err, out, 1, sticky flag for a q edge seen outside any window.

Behaviour:
- Reset: a_tgl, b_tgl, clk_tgl, op_ready, res_valid, res_q, res_err and stray_err go to 0. State goes to IDLE. Spacing counters saturate so the first operation is not delayed.
- Reset forcing the toggle lines to 0 is a visible edge to the cell when a line was 1. This is intended; a reset mid-operation abandons the operation and no result is produced.
- op_ready is registered. It is 1 only in IDLE, starting the cycle after reset deasserts, and is 0 in the cycle a handshake completes.
- Handshake: op_valid & op_ready at cycle T latches op_a/op_b. op_a/op_b are ignored outside a handshake.
- States: IDLE -> ISSUE_A -> ISSUE_B -> ISSUE_CLK -> WAIT_Q -> REPORT -> IDLE. ISSUE_A and ISSUE_B are skipped (zero cycles) when their bit is 0.
- A pulse is an inversion of the corresponding *_tgl register, held for one or more cycles.
- a pulse: cycle max(T+1, last_clk+CLK_TO_DATA).
- b pulse: cycle max(T+1, last_a+DATA_GAP, last_clk+CLK_TO_DATA), where last_a counts only an a pulse of the current operation.
- clk pulse: cycle max(T+1, last_data+DATA_TO_CLK, last_clk+CLK_TO_CLK), where last_data counts only data pulses of the current operation.
- Spacing counters are free-running, saturate at their maximum, and reset to 0 on the corresponding pulse. They persist across operations.
- Expected result: exp = ~(op_a ^ op_b).
- Window: cycles C+CLK_TO_Q-Q_WIN through C+CLK_TO_Q+Q_WIN inclusive, where C is the clk pulse cycle.
- q edge detection: a q_tgl value differing from the previous sampled value.
- REPORT: one cycle after the window closes. res_valid=1, res_q = parity of window edges, res_err = (res_q != exp) | (edges >= 2) | pending stray edge.
- res_q and res_err hold until the next res_valid; the pending-stray marker clears in REPORT.
- Stray edge: a q edge outside a window in any state. It sets stray_err (sticky until reset) and the pending marker. An edge in the REPORT cycle counts as stray for the next operation.
- Throughput: op_ready returns the cycle after REPORT.
- Saturation: counters never wrap; a counter at its maximum is always treated as satisfied.

Test Plan:
- Idle after reset, op a=1 b=1 accepted at T=0 -> a_tgl edge at 1, b_tgl at 13, clk_tgl at 32; bench toggles q at 51 -> res_valid at 56 with res_q=1, res_err=0.
- op a=0 b=0 at T=0 -> only clk_tgl edge at 1, window 16..24; q edge at 20 -> res_valid at 25, res_q=1, res_err=0.
- op a=1 b=0, no q edge -> a at 1, clk at 20, res_valid at 44 with res_q=0, res_err=0. Repeat with a q edge at 39 -> res_q=1, res_err=1.
- Back-to-back op 0/0 then op 0/0 -> second accept at 26; clk is delayed by CLK_TO_CLK to 31 (not 27); result timing shifts accordingly.
- q edge at C+10 plus a correct edge in the window -> stray_err=1 immediately, res_err=1. Two edges in the window -> res_q=0, res_err=1.
- rst_n low during ISSUE_CLK -> all outputs 0 asynchronously, no res_valid. After release op_ready=1 and the next op runs with no spacing delay.
